keypad_row_decoder: RTL and testbench

// - Consumes the rotating column strobe (col_shift_reg/column_index) and the keypad row lines.
// - Debounces presses across whole scan frames and emits one registered 4-bit key code per press.
// - Sits between the column shift register and the operand-entry/adder control logic.
// - One frame = 4 slow_clk cycles, columns 0..3.

---
 rtl/keypad_row_decoder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_keypad_row_decoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_row_decoder.sv
// Keypad row decoder: synchronises row lines, builds per-frame scan summaries and
// debounces them into one key_code/key_valid per press. KEYPAD_REPEAT_EN adds auto-repeat.
module keypad_row_decoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_FRAMES = 5,
    parameter int REPEAT_FRAMES   = 250
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic [3:0] col_shift_reg,
    input  logic [1:0] column_index,
    input  logic [3:0] row_in,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic       multi_key,
    output logic       scan_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SUM_NONE  = 2'd0,
        SUM_ONE   = 2'd1,
        SUM_MULTI = 2'd2
    } summary_t;

    localparam logic [8:0] DEB_LIMIT = 9'(DEBOUNCE_FRAMES);

    if (SYNC_STAGES < 2 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 255 ||
        REPEAT_FRAMES < 1 || REPEAT_FRAMES > 4095) begin : g_bad_params
        $error("keypad_row_decoder: parameter out of range");
    end

    // Row and column index travel through identical pipelines so they stay paired.
    logic [3:0]             row_pipe  [SYNC_STAGES];
    logic [1:0]             idx_pipe  [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] live_pipe;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                row_pipe[i] <= '0;
                idx_pipe[i] <= '0;
            end
            live_pipe <= '0;
        end else begin
            row_pipe[0] <= row_in;
            idx_pipe[0] <= column_index;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                row_pipe[i] <= row_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
            live_pipe <= {live_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    logic [3:0] s_rows;
    logic [1:0] ai;
    logic       s_live;
    logic       frame_ok;
    logic       sample_take;
    logic       frame_close;
    logic [2:0] s_hits;
    logic [1:0] row_idx;

    assign s_rows      = row_pipe[SYNC_STAGES-1];
    assign ai          = idx_pipe[SYNC_STAGES-1];
    assign s_live      = live_pipe[SYNC_STAGES-1];
    assign sample_take = s_live && (frame_ok || ai == 2'd0);
    assign frame_close = sample_take && ai == 2'd3;
    assign s_hits      = {2'b00, s_rows[0]} + {2'b00, s_rows[1]} +
                         {2'b00, s_rows[2]} + {2'b00, s_rows[3]};

    always_comb begin
        row_idx = 2'd0;
        if (s_rows[0])      row_idx = 2'd0;
        else if (s_rows[1]) row_idx = 2'd1;
        else if (s_rows[2]) row_idx = 2'd2;
        else if (s_rows[3]) row_idx = 2'd3;
    end

    // Frame accumulator: hit count saturates at 2, which is all MULTI needs.
    logic [1:0] acc_hits;
    logic [3:0] acc_code;
    logic [2:0] hit_sum;
    logic [1:0] frame_hits;
    logic [3:0] frame_code;
    summary_t   frame_sum;

    always_comb begin
        hit_sum    = {1'b0, acc_hits} + ((s_hits >= 3'd2) ? 3'd2 : s_hits);
        frame_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        frame_code = (s_hits == 3'd1) ? {ai, row_idx} : acc_code;
        case (frame_hits)
            2'd0:    frame_sum = SUM_NONE;
            2'd1:    frame_sum = SUM_ONE;
            default: frame_sum = SUM_MULTI;
        endcase
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            frame_ok <= 1'b0;
            acc_hits <= '0;
            acc_code <= '0;
        end else begin
            if (s_live && ai == 2'd0)
                frame_ok <= 1'b1;
            if (sample_take) begin
                if (frame_close) begin
                    acc_hits <= '0;
                    acc_code <= '0;
                end else begin
                    acc_hits <= frame_hits;
                    acc_code <= frame_code;
                end
            end
        end
    end

    state_t     state, state_nxt;
    logic [3:0] cand, cand_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [8:0] cnt_inc;
    logic [3:0] code_nxt;
    logic       valid_nxt, down_nxt, multi_nxt, accept;

    assign cnt_inc   = {1'b0, cnt} + 9'd1;
    assign dbg_state = state;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [12:0] REP_LIMIT = 13'(REPEAT_FRAMES);
    logic [11:0] rep_cnt, rep_nxt;
    logic [12:0] rep_inc;
    assign rep_inc = {1'b0, rep_cnt} + 13'd1;
`endif

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        code_nxt  = key_code;
        down_nxt  = key_down;
        valid_nxt = 1'b0;
        multi_nxt = multi_key;
        accept    = 1'b0;
        if (frame_close) begin
            multi_nxt = (frame_sum == SUM_MULTI);
            case (state)
                S_IDLE: begin
                    if (frame_sum == SUM_ONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = S_DEBOUNCE;
                            cand_nxt  = frame_code;
                            cnt_nxt   = 8'd1;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_sum == SUM_ONE && frame_code == cand) begin
                        if (cnt_inc >= DEB_LIMIT) accept = 1'b1;
                        else                      cnt_nxt = cnt_inc[7:0];
                    end else begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = 8'd0;
                    end
                end
                S_PRESSED: begin
                    if (frame_sum == SUM_NONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_nxt = S_IDLE;
                            down_nxt  = 1'b0;
                            cnt_nxt   = 8'd0;
                        end else begin
                            state_nxt = S_RELEASE;
                            cnt_nxt   = 8'd1;
                        end
                    end
                end
                default: begin
                    if (frame_sum == SUM_NONE) begin
                        if (cnt_inc >= DEB_LIMIT) begin
                            state_nxt = S_IDLE;
                            down_nxt  = 1'b0;
                            cnt_nxt   = 8'd0;
                        end else begin
                            cnt_nxt = cnt_inc[7:0];
                        end
                    end else begin
                        state_nxt = S_PRESSED;
                        cnt_nxt   = 8'd0;
                    end
                end
            endcase
            if (accept) begin
                state_nxt = S_PRESSED;
                code_nxt  = frame_code;
                valid_nxt = 1'b1;
                down_nxt  = 1'b1;
                cnt_nxt   = 8'd0;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        // Only frames spent staying in PRESSED advance the repeat counter.
        rep_nxt = rep_cnt;
        if (frame_close) begin
            if (state == S_PRESSED && state_nxt == S_PRESSED) begin
                if (rep_inc >= REP_LIMIT) begin
                    valid_nxt = 1'b1;
                    rep_nxt   = '0;
                end else begin
                    rep_nxt = rep_inc[11:0];
                end
            end else begin
                rep_nxt = '0;
            end
        end
`endif
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_down  <= down_nxt;
            multi_key <= multi_nxt;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_nxt;
    end
`endif

    // Strobe consistency is monitored on the undelayed inputs and never feeds the FSM.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) scan_err <= 1'b0;
        else if (col_shift_reg != (4'b0001 << column_index)) scan_err <= 1'b1;
    end

endmodule

// File: tb/tb_keypad_row_decoder.sv
// Bench for keypad_row_decoder: a scan process models the keypad matrix, a monitor
// pops expected key codes from a queue on every key_valid pulse.
`timescale 1ns/1ps
module tb_keypad_row_decoder;

    localparam int DF = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam int RF = 3;
`else
    localparam int RF = 250;
`endif
    localparam logic [1:0] ST_IDLE = 2'd0, ST_DEB = 2'd1, ST_PRESSED = 2'd2, ST_RELEASE = 2'd3;

    logic       slow_clk;
    logic       rst;
    logic [3:0] col_shift_reg;
    logic [1:0] column_index;
    logic [3:0] row_in;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       multi_key;
    logic       scan_err;
    logic [1:0] dbg_state;

    keypad_row_decoder #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_FRAMES(DF),
        .REPEAT_FRAMES  (RF)
    ) dut (
        .slow_clk     (slow_clk),
        .rst          (rst),
        .col_shift_reg(col_shift_reg),
        .column_index (column_index),
        .row_in       (row_in),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .key_down     (key_down),
        .multi_key    (multi_key),
        .scan_err     (scan_err),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial begin
        slow_clk = 1'b0;
        forever #5 slow_clk = ~slow_clk;
    end

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         pulse_cnt    = 0;
    int         last_pulse   = -1000;
    int         rep_gap_bad  = 0;
    logic       rep_phase    = 1'b0;
    logic [3:0] last_code    = 4'h0;
    logic [3:0] key_mat [4];
    logic       break_strobe;
    logic [3:0] exp_q [$];
    logic [1:0] col;

    always @(posedge slow_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge slow_clk);
    endtask

    task automatic settle();
        @(negedge slow_clk);
        #1;
    endtask

    // Keypad model: rotating column strobe, rows reflect the pressed keys of that column.
    initial begin
        col           = 2'd0;
        column_index  = 2'd0;
        col_shift_reg = 4'b0001;
        row_in        = 4'b0000;
        forever begin
            @(posedge slow_clk);
            #1;
            col           = col + 2'd1;
            column_index  = col;
            col_shift_reg = break_strobe ? 4'b0110 : (4'b0001 << col);
            row_in        = key_mat[col];
        end
    end

    // Scoreboard monitor
    always @(negedge slow_clk) begin
        if (!rst && key_valid) begin
            pulse_cnt++;
            if (exp_q.size() > 0) begin
                check("key_code_on_pulse", {28'b0, key_code}, {28'b0, exp_q.pop_front()});
            end else begin
`ifdef KEYPAD_REPEAT_EN
                tests_run++;
                if (key_code != last_code || (cyc - last_pulse) < 12 || ((cyc - last_pulse) % 4) != 0) begin
                    tests_failed++;
                    $display("FAIL repeat_pulse: code %0h gap %0d, expected code %0h gap >=12",
                             key_code, cyc - last_pulse, last_code);
                end
                if (rep_phase && (cyc - last_pulse) != 12) rep_gap_bad++;
`else
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_key_valid: got pulse with code %0h, expected no pulse (cycle %0d)",
                         key_code, cyc);
`endif
            end
            last_pulse = cyc;
            last_code  = key_code;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "timeout");
    end

    int pc0;

    initial begin
        rst          = 1'b1;
        break_strobe = 1'b0;
        for (int i = 0; i < 4; i++) key_mat[i] = 4'b0000;

        // 1. reset state and idle keypad
        wait_cycles(3);
        settle();
        check("rst_key_valid", key_valid, 0);
        check("rst_key_down", key_down, 0);
        check("rst_key_code", key_code, 0);
        check("rst_multi_key", multi_key, 0);
        check("rst_scan_err", scan_err, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge slow_clk);
        rst = 1'b0;
        wait_cycles(100);
        settle();
        check("idle_no_pulse", pulse_cnt, 0);
        check("idle_key_down", key_down, 0);
        check("idle_multi", multi_key, 0);
        check("idle_scan_err", scan_err, 0);

        // 2. press col2,row1 -> code 1001
        exp_q.push_back(4'b1001);
        key_mat[2] = 4'b0010;
        wait_cycles(40);
        settle();
        check("press_pulse_seen", exp_q.size(), 0);
`ifndef KEYPAD_REPEAT_EN
        check("press_one_pulse", pulse_cnt, 1);
`endif
        check("press_key_down", key_down, 1);
        check("press_key_code", key_code, 4'b1001);
        check("press_state", dbg_state, ST_PRESSED);

        // 4. short release does not end the press; long release does
        pc0 = pulse_cnt;
        key_mat[2] = 4'b0000;
        wait_cycles(12);
        settle();
        check("short_rel_state", dbg_state, ST_RELEASE);
        check("short_rel_down", key_down, 1);
        key_mat[2] = 4'b0010;
        wait_cycles(16);
        settle();
        check("repress_key_down", key_down, 1);
        check("repress_state", dbg_state, ST_PRESSED);
`ifndef KEYPAD_REPEAT_EN
        check("repress_no_pulse", pulse_cnt, pc0);
`endif
        key_mat[2] = 4'b0000;
        wait_cycles(40);
        settle();
        check("long_rel_key_down", key_down, 0);
        check("long_rel_code_held", key_code, 4'b1001);
        check("long_rel_state", dbg_state, ST_IDLE);

        // 3. bounce on col1,row3 then stable -> code 0111
        pc0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            key_mat[1] = (i % 2 == 0) ? 4'b1000 : 4'b0000;
            wait_cycles(3);
        end
        settle();
        check("bounce_no_pulse", pulse_cnt, pc0);
        check("bounce_key_down", key_down, 0);
        exp_q.push_back(4'b0111);
        key_mat[1] = 4'b1000;
        wait_cycles(40);
        settle();
        check("bounce_pulse_seen", exp_q.size(), 0);
        check("bounce_key_down_after", key_down, 1);
        check("bounce_key_code", key_code, 4'b0111);
        key_mat[1] = 4'b0000;
        wait_cycles(40);
        settle();
        check("bounce_released", key_down, 0);

        // 5. two keys at once -> multi_key, never a pulse
        pc0 = pulse_cnt;
        key_mat[0] = 4'b0001;
        key_mat[3] = 4'b0100;
        wait_cycles(40);
        settle();
        check("multi_flag", multi_key, 1);
        check("multi_state", dbg_state, ST_IDLE);
        check("multi_key_down", key_down, 0);
        check("multi_no_pulse", pulse_cnt, pc0);
        key_mat[0] = 4'b0000;
        key_mat[3] = 4'b0000;
        wait_cycles(12);
        settle();
        check("multi_cleared", multi_key, 0);
        key_mat[1] = 4'b0101;
        wait_cycles(20);
        settle();
        check("multi_same_col", multi_key, 1);
        check("multi_same_col_state", dbg_state, ST_IDLE);
        key_mat[1] = 4'b0000;
        wait_cycles(12);
        settle();
        check("multi_same_col_no_pulse", pulse_cnt, pc0);

        // 6. long hold of col3,row3 -> code 1111, repeat only when enabled
        pc0 = pulse_cnt;
        rep_phase = 1'b1;
        exp_q.push_back(4'b1111);
        key_mat[3] = 4'b1000;
        wait_cycles(160);
        settle();
        check("hold_pulse_seen", exp_q.size(), 0);
        check("hold_key_code", key_code, 4'b1111);
`ifdef KEYPAD_REPEAT_EN
        check("hold_repeat_many", (pulse_cnt - pc0) >= 10, 1);
        check("hold_repeat_gap", rep_gap_bad, 0);
`else
        check("hold_single_pulse", pulse_cnt - pc0, 1);
`endif
        key_mat[3] = 4'b0000;
        wait_cycles(40);
        rep_phase = 1'b0;
        settle();
        check("hold_released", key_down, 0);

        // scan_err: one bad strobe, sticky, FSM untouched
        check("scan_err_clean", scan_err, 0);
        break_strobe = 1'b1;
        wait_cycles(2);
        break_strobe = 1'b0;
        settle();
        check("scan_err_set", scan_err, 1);
        wait_cycles(8);
        settle();
        check("scan_err_sticky", scan_err, 1);
        check("scan_err_state", dbg_state, ST_IDLE);

        // async reset while a key is held: col0,row2 -> code 0010
        exp_q.push_back(4'b0010);
        key_mat[0] = 4'b0100;
        wait_cycles(40);
        settle();
        check("pre_rst_pulse_seen", exp_q.size(), 0);
        check("pre_rst_key_down", key_down, 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_key_down", key_down, 0);
        check("async_rst_key_code", key_code, 0);
        check("async_rst_scan_err", scan_err, 0);
        check("async_rst_state", dbg_state, ST_IDLE);
        key_mat[0] = 4'b0000;
        @(negedge slow_clk);
        rst = 1'b0;
        wait_cycles(40);
        settle();
        check("post_rst_key_down", key_down, 0);

        // reset in the middle of debounce discards the candidate
        pc0 = pulse_cnt;
        key_mat[2] = 4'b0001;
        wait_cycles(14);
        settle();
        check("mid_deb_state", dbg_state, ST_DEB);
        rst = 1'b1;
        #1;
        check("mid_deb_rst_state", dbg_state, ST_IDLE);
        key_mat[2] = 4'b0000;
        @(negedge slow_clk);
        rst = 1'b0;
        wait_cycles(60);
        settle();
        check("mid_deb_no_pulse", pulse_cnt, pc0);
        check("mid_deb_key_down", key_down, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
